// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared entry type, drain states and strobe constant for the store buffer
package sb_pkg;

  localparam logic [3:0] STRB_FULL = 4'hF;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  strb;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SB_IDLE,
    SB_REQ,
    SB_WAIT
  } sb_state_t;

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store, load-check and memory write-port bundle of the store buffer
interface store_buffer_if;

  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_strb;

  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_done;

  // Buffer side
  modport slave (
    input  st_valid, st_addr, st_data, st_strb,
    output st_ready,
    input  ld_valid, ld_addr,
    output ld_stall, ld_fwd_valid, ld_fwd_data,
    output mem_req, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_done
  );

  // Pipeline / memory side
  modport master (
    output st_valid, st_addr, st_data, st_strb,
    input  st_ready,
    output ld_valid, ld_addr,
    input  ld_stall, ld_fwd_valid, ld_fwd_data,
    input  mem_req, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_done
  );

endinterface

// File: rtl/store_buffer_fifo.sv
// rtl/store_buffer_fifo.sv - in-order entry storage with wrap-bit pointers and per-entry valid
module store_buffer_fifo
  import sb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  sb_entry_t                    i_entry,
  input  logic                         i_pop,
  output sb_entry_t                    o_head,
  output sb_entry_t                    o_entries [DEPTH],
  output logic [DEPTH-1:0]             o_valid,
  output logic [$clog2(DEPTH)-1:0]     o_rd_idx,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] w_diff;
  sb_entry_t   r_mem [DEPTH];

  // Pointer advance; the extra MSB separates full from empty
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents only matter where o_valid is set, so no reset
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_entry;
  end

  assign w_diff    = r_wr_ptr - r_rd_ptr;
  assign o_count   = w_diff;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rd_idx  = r_rd_ptr[AW-1:0];
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign o_entries = r_mem;

  // A slot is live when its distance from the head is below the count
  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    assign o_valid[g] = ({1'b0, AW'(g) - r_rd_ptr[AW-1:0]} < w_diff);
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write buffer with drain FSM and load hazard check; STORE_FWD_EN enables full-word forwarding
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  store_buffer_if.slave              io_sb,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  sb_entry_t        w_entry;
  sb_entry_t        w_head;
  sb_entry_t        w_young;
  sb_entry_t        w_entries [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic [AW-1:0]    w_rd_idx;
  logic [AW-1:0]    w_idx;
  logic             w_push;
  logic             w_pop;
  logic             w_match;
  logic             w_hit;
  logic             w_unused_bits;

  sb_state_t        r_state;
  logic             r_mem_req;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic [3:0]       r_mem_wstrb;

  // An all-zero strobe writes nothing, so it never takes a slot
  assign io_sb.st_ready = !o_full;
  assign w_push  = io_sb.st_valid && !o_full && (io_sb.st_strb != 4'b0000);
  assign w_pop   = (r_state == SB_WAIT) && io_sb.mem_done;
  assign w_entry = '{waddr: io_sb.st_addr[31:2], data: io_sb.st_data, strb: io_sb.st_strb};

  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (w_push),
    .i_entry   (w_entry),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_entries (w_entries),
    .o_valid   (w_valid),
    .o_rd_idx  (w_rd_idx),
    .o_count   (o_count),
    .o_full    (o_full),
    .o_empty   (o_empty)
  );

  // Drain FSM: latch the head on entry to REQ so the write fields hold steady
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= SB_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      case (r_state)
        SB_IDLE: begin
          if (!o_empty) begin
            r_state     <= SB_REQ;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= {w_head.waddr, 2'b00};
            r_mem_wdata <= w_head.data;
            r_mem_wstrb <= w_head.strb;
          end
        end
        SB_REQ: begin
          if (io_sb.mem_gnt) begin
            r_state   <= SB_WAIT;
            r_mem_req <= 1'b0;
          end
        end
        SB_WAIT: begin
          if (io_sb.mem_done) r_state <= SB_IDLE;
        end
        default: begin
          r_state   <= SB_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign io_sb.mem_req   = r_mem_req;
  assign io_sb.mem_addr  = r_mem_addr;
  assign io_sb.mem_wdata = r_mem_wdata;
  assign io_sb.mem_wstrb = r_mem_wstrb;

  // Walk from head to tail so the last match found is the youngest store
  always_comb begin
    w_match = 1'b0;
    w_young = '0;
    w_idx   = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_idx = w_rd_idx + AW'(j);
      if (w_valid[w_idx] && (w_entries[w_idx].waddr == io_sb.ld_addr[31:2])) begin
        w_match = 1'b1;
        w_young = w_entries[w_idx];
      end
    end
  end

  assign w_hit = io_sb.ld_valid && w_match;

`ifdef STORE_FWD_EN
  // Only a full-word youngest store can supply the load; partial ones stall it
  assign io_sb.ld_fwd_valid = w_hit && (w_young.strb == STRB_FULL);
  assign io_sb.ld_fwd_data  = io_sb.ld_fwd_valid ? w_young.data : 32'h0;
  assign io_sb.ld_stall     = w_hit && (w_young.strb != STRB_FULL);
`else
  assign io_sb.ld_fwd_valid = 1'b0;
  assign io_sb.ld_fwd_data  = 32'h0;
  assign io_sb.ld_stall     = w_hit;
`endif

  assign w_unused_bits = ^{io_sb.st_addr[1:0], io_sb.ld_addr[1:0], w_young};

endmodule
